// File: rtl/jtframe_ddram_pkg.sv
// Shared definitions for the DDRAM arbiter slice.
//   - FSM state encoding of the burst sequencer
//   - requester indices (loader = ROM download reader, client = R/W user)
//   - DDRAM bus width constants
package jtframe_ddram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic REQ_LOADER = 1'b0;
  localparam logic REQ_CLIENT = 1'b1;

  localparam int DDR_DW  = 64;
  localparam int DDR_BEW = 8;
  localparam int DDR_AW  = 29;
  localparam int DDR_BCW = 8;

endpackage

// File: rtl/jtframe_ddram_arb_if.sv
// Bundle of every bus signal around jtframe_ddram_arb: both requester
// ports plus the DDRAM Avalon side.
//   slave  : arbiter view (requests and DDR responses in, grants/commands out)
//   master : environment view (requesters and DDR controller)
interface jtframe_ddram_arb_if #(
  parameter int AW  = jtframe_ddram_pkg::DDR_AW,
  parameter int BCW = jtframe_ddram_pkg::DDR_BCW
);
  import jtframe_ddram_pkg::*;

  // requester 0: read-only loader
  logic                r0_req;
  logic [AW-1:0]       r0_addr;
  logic [BCW-1:0]      r0_burstcnt;
  logic                r0_gnt;
  logic [DDR_DW-1:0]   r0_dout;
  logic                r0_dout_ready;
  logic                r0_done;
  // requester 1: read/write client
  logic                r1_req;
  logic [AW-1:0]       r1_addr;
  logic [BCW-1:0]      r1_burstcnt;
  logic                r1_we;
  logic [DDR_DW-1:0]   r1_din;
  logic [DDR_BEW-1:0]  r1_be;
  logic                r1_gnt;
  logic [DDR_DW-1:0]   r1_dout;
  logic                r1_dout_ready;
  logic                r1_done;
  logic                r1_din_rd;
  // DDRAM Avalon port
  logic                ddram_busy;
  logic [AW-1:0]       ddram_addr;
  logic [BCW-1:0]      ddram_burstcnt;
  logic                ddram_rd;
  logic                ddram_we;
  logic [DDR_DW-1:0]   ddram_din;
  logic [DDR_BEW-1:0]  ddram_be;
  logic [DDR_DW-1:0]   ddram_dout;
  logic                ddram_dout_ready;

  modport slave (
    input  r0_req, r0_addr, r0_burstcnt,
    input  r1_req, r1_addr, r1_burstcnt, r1_we, r1_din, r1_be,
    input  ddram_busy, ddram_dout, ddram_dout_ready,
    output r0_gnt, r0_dout, r0_dout_ready, r0_done,
    output r1_gnt, r1_dout, r1_dout_ready, r1_done, r1_din_rd,
    output ddram_addr, ddram_burstcnt, ddram_rd, ddram_we, ddram_din, ddram_be
  );

  modport master (
    output r0_req, r0_addr, r0_burstcnt,
    output r1_req, r1_addr, r1_burstcnt, r1_we, r1_din, r1_be,
    output ddram_busy, ddram_dout, ddram_dout_ready,
    input  r0_gnt, r0_dout, r0_dout_ready, r0_done,
    input  r1_gnt, r1_dout, r1_dout_ready, r1_done, r1_din_rd,
    input  ddram_addr, ddram_burstcnt, ddram_rd, ddram_we, ddram_din, ddram_be
  );

endinterface

// File: rtl/jtframe_rr_arb2.sv
// Two-way round-robin picker.
//   i_req     : request vector {req1, req0}
//   i_upd     : strobe, the requester i_upd_idx has just been served
//   i_upd_idx : index recorded as last served
//   o_any     : at least one request pending
//   o_sel     : winning index (valid when o_any)
// After reset the last-served flag is 1, so requester 0 wins the first tie.
module jtframe_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_idx,
  output logic       o_any,
  output logic       o_sel
);

  logic r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_last <= 1'b1;
    else if (i_upd) r_last <= i_upd_idx;
  end

  always_comb begin
    o_any = |i_req;
    if (&i_req) o_sel = ~r_last;   // tie: whoever was not served last
    else        o_sel = i_req[1];
  end

endmodule

// File: rtl/jtframe_ddram_arb.sv
// Arbiter and burst sequencer sharing the MiSTer DDRAM Avalon port between
// the ROM loader (requester 0, reads) and a R/W client (requester 1).
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   bus        : jtframe_ddram_arb_if.slave, requester ports + DDRAM port
// Flow: IDLE -> (grant) -> RD_CMD -> RD_DATA -> DONE -> IDLE
//                       -> WR ------------------> DONE
//                       -> DONE (zero-length burst)
module jtframe_ddram_arb
  import jtframe_ddram_pkg::*;
#(
  parameter int AW  = DDR_AW,
  parameter int BCW = DDR_BCW
) (
  input logic                clk,
  input logic                rst_n,
  jtframe_ddram_arb_if.slave bus
);

  state_t         r_state, w_next;
  logic           r_owner;
  logic [AW-1:0]  r_addr;
  logic [BCW-1:0] r_bcnt;
  logic [BCW-1:0] r_cnt;
  logic [1:0]     r_gnt;

  logic           w_any, w_sel, w_sel_we;
  logic [AW-1:0]  w_sel_addr;
  logic [BCW-1:0] w_sel_bc;
  logic [BCW-1:0] w_cnt_nx;
  logic           w_beat, w_last;

  jtframe_rr_arb2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     ({bus.r1_req, bus.r0_req}),
    .i_upd     (r_state == ST_DONE),
    .i_upd_idx (r_owner),
    .o_any     (w_any),
    .o_sel     (w_sel)
  );

  // loader never writes, so only the client's we matters
  assign w_sel_addr = w_sel ? bus.r1_addr     : bus.r0_addr;
  assign w_sel_bc   = w_sel ? bus.r1_burstcnt : bus.r0_burstcnt;
  assign w_sel_we   = w_sel & bus.r1_we;

  // beat accepted this cycle; stray dout_ready outside RD_DATA is dropped
  always_comb begin
    w_beat = 1'b0;
    case (r_state)
      ST_RD_DATA: w_beat = bus.ddram_dout_ready;
      ST_WR:      w_beat = !bus.ddram_busy;
      default:    w_beat = 1'b0;
    endcase
  end

  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_last   = w_beat && (w_cnt_nx == r_bcnt);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          if (w_sel_bc == '0) w_next = ST_DONE;
          else if (w_sel_we)  w_next = ST_WR;
          else                w_next = ST_RD_CMD;
        end
      end
      ST_RD_CMD:  if (!bus.ddram_busy) w_next = ST_RD_DATA;
      ST_RD_DATA: if (w_last) w_next = ST_DONE;
      ST_WR:      if (w_last) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // command registers, beat counter and grant pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= REQ_LOADER;
      r_addr  <= '0;
      r_bcnt  <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_gnt <= '0;
      if (r_state == ST_IDLE && w_any) begin
        r_owner <= w_sel;
        r_addr  <= w_sel_addr;
        r_bcnt  <= w_sel_bc;
        r_cnt   <= '0;
        r_gnt   <= w_sel ? 2'b10 : 2'b01;
      end else if (r_state == ST_RD_CMD) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= w_cnt_nx;
      end
    end
  end

  // outputs: strobes decode from state, so reset forces them low at once
  always_comb begin
    bus.ddram_rd      = (r_state == ST_RD_CMD);
    bus.ddram_we      = (r_state == ST_WR);
    bus.r0_done       = (r_state == ST_DONE) && (r_owner == REQ_LOADER);
    bus.r1_done       = (r_state == ST_DONE) && (r_owner == REQ_CLIENT);
    bus.r0_dout_ready = (r_state == ST_RD_DATA) && (r_owner == REQ_LOADER) && bus.ddram_dout_ready;
    bus.r1_dout_ready = (r_state == ST_RD_DATA) && (r_owner == REQ_CLIENT) && bus.ddram_dout_ready;
    bus.r1_din_rd     = (r_state == ST_WR) && !bus.ddram_busy;
  end

  assign bus.r0_gnt         = r_gnt[0];
  assign bus.r1_gnt         = r_gnt[1];
  assign bus.ddram_addr     = r_addr;
  assign bus.ddram_burstcnt = r_bcnt;
  assign bus.ddram_din      = bus.r1_din;
  assign bus.ddram_be       = bus.r1_be;
  assign bus.r0_dout        = bus.ddram_dout;
  assign bus.r1_dout        = bus.ddram_dout;

endmodule
